// File: rtl/arc_stim_sequencer.sv
// -----------------------------------------------------------------------------
// arc_stim_sequencer
//
// Stimulus sequencer for the ARC datapath system. After a start request it
// holds sys_rst_o high for RST_CYCLES cycles, then emits a train of one-hot
// acknowledge pulses (GAP_CYCLES idle, PULSE_W high) rotating round-robin over
// NUM_CH channels. NUM_PULSES=0 runs continuously until stop_i.
//
// Optional build macro: ARC_STIM_HANDSHAKE_EN
//   Adds req_i. A gap only ends once req_i[ch_idx] is high, and a pulse is
//   stretched past PULSE_W until req_i[ch_idx] drops.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_i      begin a run (accepted in IDLE or DONE only)
//   stop_i       abort the current run, go to DONE
//   req_i        per-channel request (handshake build only)
//   sys_rst_o    generated datapath reset, active-high
//   ack_o        one-hot acknowledge pulses
//   busy_o       run in progress (RESET, GAP, PULSE)
//   done_o       run finished or aborted
//   pulse_cnt_o  pulses completed in the current run
//   ch_idx_o     channel receiving the current or next pulse
// -----------------------------------------------------------------------------
module arc_stim_sequencer #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned GAP_CYCLES = 10,
   parameter int unsigned PULSE_W    = 2,
   parameter int unsigned NUM_PULSES = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
`ifdef ARC_STIM_HANDSHAKE_EN
   input  logic [NUM_CH-1:0] req_i,
`endif
   output logic              sys_rst_o,
   output logic [NUM_CH-1:0] ack_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       pulse_cnt_o,
   output logic [3:0]        ch_idx_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_GAP   = 3'd2,
      S_PULSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [15:0] RST_INIT = 16'(RST_CYCLES - 32'd1);
   localparam logic [15:0] GAP_INIT = 16'(GAP_CYCLES - 32'd1);
   localparam logic [15:0] PW_INIT  = 16'(PULSE_W - 32'd1);
   localparam logic [15:0] N_PULSE  = 16'(NUM_PULSES);
   localparam logic [3:0]  CH_LAST  = 4'(NUM_CH - 32'd1);

   // Reject out-of-range parameters at elaboration
   if (NUM_CH < 32'd1 || NUM_CH > 32'd16 || RST_CYCLES < 32'd1 || RST_CYCLES > 32'd255 ||
       GAP_CYCLES < 32'd1 || GAP_CYCLES > 32'd65535 || PULSE_W < 32'd1 || PULSE_W > 32'd255 ||
       NUM_PULSES > 32'd65535 || CLK_FREQ == 32'd0) begin : g_bad_param
      $error("arc_stim_sequencer: parameter out of range");
   end

   function automatic logic [NUM_CH-1:0] onehot(input logic [3:0] idx);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         oh[i] = (idx == i[3:0]);
      end
      return oh;
   endfunction

   state_t            state_q, state_d;
   logic [15:0]       timer_q, timer_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [3:0]        ch_q, ch_d;
   logic              sys_rst_q, busy_q, done_q;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [3:0]        ch_next_s;
   logic [15:0]       cnt_inc_s;
   logic              gap_go_s;
   logic              pulse_hold_s;

`ifdef ARC_STIM_HANDSHAKE_EN
   // Gap waits for the current channel's request; the pulse follows it
   assign gap_go_s     = |(req_i & onehot(ch_q));
   assign pulse_hold_s = |(req_i & onehot(ch_q));
`else
   assign gap_go_s     = 1'b1;
   assign pulse_hold_s = 1'b0;
`endif

   assign ch_next_s = (ch_q == CH_LAST) ? 4'd0 : ch_q + 4'd1;
   assign cnt_inc_s = cnt_q + 16'd1;

   // Next-state logic; stop outranks start, which outranks timer expiry
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (!stop_i && start_i) begin
               state_d = S_RESET;
               timer_d = RST_INIT;
               cnt_d   = 16'd0;
               ch_d    = 4'd0;
            end else begin
               state_d = state_q;
            end
         end
         S_RESET: begin
            if (stop_i) begin
               state_d = S_DONE;
            end else if (timer_q == 16'd0) begin
               state_d = S_GAP;
               timer_d = GAP_INIT;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_GAP: begin
            if (stop_i) begin
               state_d = S_DONE;
            end else if (timer_q != 16'd0) begin
               timer_d = timer_q - 16'd1;
            end else if (gap_go_s) begin
               state_d = S_PULSE;
               timer_d = PW_INIT;
            end else begin
               timer_d = 16'd0;
            end
         end
         S_PULSE: begin
            if (stop_i) begin
               // Truncated pulse is not counted
               state_d = S_DONE;
            end else if (timer_q != 16'd0) begin
               timer_d = timer_q - 16'd1;
            end else if (!pulse_hold_s) begin
               cnt_d = cnt_inc_s;
               ch_d  = ch_next_s;
               if ((NUM_PULSES != 32'd0) && (cnt_inc_s == N_PULSE)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_GAP;
                  timer_d = GAP_INIT;
               end
            end else begin
               timer_d = 16'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with it
   always_comb begin
      if (state_d == S_PULSE) begin
         ack_d = onehot(ch_d);
      end else begin
         ack_d = '0;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         timer_q   <= 16'd0;
         cnt_q     <= 16'd0;
         ch_q      <= 4'd0;
         sys_rst_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_q     <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         ch_q      <= ch_d;
         sys_rst_q <= (state_d == S_RESET);
         busy_q    <= (state_d == S_RESET) || (state_d == S_GAP) || (state_d == S_PULSE);
         done_q    <= (state_d == S_DONE);
         ack_q     <= ack_d;
      end
   end

   assign sys_rst_o   = sys_rst_q;
   assign ack_o       = ack_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pulse_cnt_o = cnt_q;
   assign ch_idx_o    = ch_q;

endmodule

// File: tb/tb_arc_stim_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for arc_stim_sequencer. Three instances share one stimulus stream:
//   u0: defaults (2 ch, 5 pulses), u1: 3 ch / 7 pulses, u2: 4 ch continuous.
// Expected outputs come from a closed-form model of the run timeline:
// cycle t after start -> reset phase, then pulse k = (t-R)/(G+W).
// -----------------------------------------------------------------------------
module tb_arc_stim_sequencer;

   typedef struct packed {
      logic        sr;
      logic [15:0] ack;
      logic        busy;
      logic        done;
      logic [15:0] cnt;
      logic [3:0]  ch;
   } obs_t;

   localparam int PR [3] = '{4, 2, 3};
   localparam int PG [3] = '{10, 3, 2};
   localparam int PW [3] = '{2, 1, 1};
   localparam int PCH[3] = '{2, 3, 4};
   localparam int PN [3] = '{5, 7, 0};

   logic clk = 1'b0;
   logic rst, start, stop;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   cmp_en   = 1'b0;

   logic       sr0, sr1, sr2, busy0, busy1, busy2, done0, done1, done2;
   logic [1:0] ack0;
   logic [2:0] ack1;
   logic [3:0] ack2;
   logic [15:0] cnt0, cnt1, cnt2;
   logic [3:0]  ch0, ch1, ch2;

   always #5 clk = ~clk;

   arc_stim_sequencer u0 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
`ifdef ARC_STIM_HANDSHAKE_EN
      .req_i(~ack0),
`endif
      .sys_rst_o(sr0), .ack_o(ack0), .busy_o(busy0), .done_o(done0),
      .pulse_cnt_o(cnt0), .ch_idx_o(ch0));

   arc_stim_sequencer #(.NUM_CH(3), .RST_CYCLES(2), .GAP_CYCLES(3), .PULSE_W(1), .NUM_PULSES(7)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
`ifdef ARC_STIM_HANDSHAKE_EN
      .req_i(~ack1),
`endif
      .sys_rst_o(sr1), .ack_o(ack1), .busy_o(busy1), .done_o(done1),
      .pulse_cnt_o(cnt1), .ch_idx_o(ch1));

   arc_stim_sequencer #(.NUM_CH(4), .RST_CYCLES(3), .GAP_CYCLES(2), .PULSE_W(1), .NUM_PULSES(0)) u2 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
`ifdef ARC_STIM_HANDSHAKE_EN
      .req_i(~ack2),
`endif
      .sys_rst_o(sr2), .ack_o(ack2), .busy_o(busy2), .done_o(done2),
      .pulse_cnt_o(cnt2), .ch_idx_o(ch2));

   obs_t act [3];
   assign act[0] = '{sr0, 16'(ack0), busy0, done0, cnt0, ch0};
   assign act[1] = '{sr1, 16'(ack1), busy1, done1, cnt1, ch1};
   assign act[2] = '{sr2, 16'(ack2), busy2, done2, cnt2, ch2};

   // Outputs of instance i at cycle t of an uninterrupted run
   function automatic obs_t model_at(int i, int t);
      obs_t        e;
      int          u, k, w, p;
      logic [15:0] one;
      e   = '0;
      one = 16'd1;
      p   = PG[i] + PW[i];
      if (t < PR[i]) begin
         e.sr   = 1'b1;
         e.busy = 1'b1;
      end else begin
         u = t - PR[i];
         k = u / p;
         w = u % p;
         if (PN[i] != 0 && k >= PN[i]) begin
            e.done = 1'b1;
            e.cnt  = 16'(PN[i]);
            e.ch   = 4'(PN[i] % PCH[i]);
         end else begin
            e.busy = 1'b1;
            e.cnt  = 16'(k);
            e.ch   = 4'(k % PCH[i]);
            e.ack  = (w >= PG[i]) ? (one << (k % PCH[i])) : 16'd0;
         end
      end
      return e;
   endfunction

   // mode 0: idle, 1: running at cycle m_t, 2: aborted with frozen counters
   int   m_mode [3] = '{0, 0, 0};
   int   m_t    [3] = '{0, 0, 0};
   obs_t m_frz  [3];

   function automatic obs_t expected(int i);
      obs_t e;
      e = '0;
      if (m_mode[i] == 1) begin
         e = model_at(i, m_t[i]);
      end else if (m_mode[i] == 2) begin
         e.done = 1'b1;
         e.cnt  = m_frz[i].cnt;
         e.ch   = m_frz[i].ch;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_mode[i] = 0;
         end else if (m_mode[i] == 1 && model_at(i, m_t[i]).busy) begin
            if (stop) begin
               m_frz[i]  = model_at(i, m_t[i]);
               m_mode[i] = 2;
            end else begin
               m_t[i] = m_t[i] + 1;
            end
         end else if (!stop && start) begin
            m_mode[i] = 1;
            m_t[i]    = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            obs_t e;
            e = expected(i);
            n_checks++;
            if (act[i] !== e) begin
               n_fail++;
               $display("FAIL model_u%0d t=%0t actual sr=%b ack=%h busy=%b done=%b cnt=%0d ch=%0d required sr=%b ack=%h busy=%b done=%b cnt=%0d ch=%0d",
                        i, $time, act[i].sr, act[i].ack, act[i].busy, act[i].done, act[i].cnt, act[i].ch,
                        e.sr, e.ack, e.busy, e.done, e.cnt, e.ch);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
      n_checks++;
      if (a !== r) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, r);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      obs_t pm;
      rst = 1'b1; start = 1'b0; stop = 1'b0;

      // Hand-computed points that pin the model
      pm = model_at(0, 14); chk("model_ack_first", 32'(pm.ack), 32'h1);
      pm = model_at(0, 26); chk("model_ack_second", 32'(pm.ack), 32'h2);
      pm = model_at(0, 64); chk("model_done_cnt", 32'(pm.cnt), 32'd5);
      pm = model_at(1, 30); chk("model_u1_ch_done", 32'(pm.ch), 32'd1);
      pm = model_at(2, 303); chk("model_u2_cnt100", 32'(pm.cnt), 32'd100);

      repeat (3) cyc();
      cmp_en = 1'b1;
      chk("reset_busy", 32'(busy0), 32'd0);
      chk("reset_cnt", 32'(cnt0), 32'd0);
      rst = 1'b0;
      cyc();

      // Basic run, u0 defaults
      start = 1'b1; cyc(); start = 1'b0;        // cycle 0
      chk("sysrst_t0", 32'(sr0), 32'd1);
      repeat (3) cyc(); chk("sysrst_t3", 32'(sr0), 32'd1);
      cyc();            chk("sysrst_t4", 32'(sr0), 32'd0);
      repeat (10) cyc(); chk("ack_t14", 32'(ack0), 32'd1);
      cyc();            chk("ack_t15", 32'(ack0), 32'd1);
      cyc();            chk("ack_t16", 32'(ack0), 32'd0);
      chk("cnt_t16", 32'(cnt0), 32'd1);
      repeat (10) cyc(); chk("ack_t26", 32'(ack0), 32'd2);
      repeat (38) cyc();                          // cycle 64
      chk("done_t64", 32'(done0), 32'd1);
      chk("cnt_t64", 32'(cnt0), 32'd5);
      chk("u1_cnt_done", 32'(cnt1), 32'd7);
      chk("u1_ch_done", 32'(ch1), 32'd1);

      // Stop in the 2nd cycle of the 3rd pulse
      start = 1'b1; cyc(); start = 1'b0;
      repeat (39) cyc(); chk("ack_pulse3", 32'(ack0), 32'd1);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("stop_ack", 32'(ack0), 32'd0);
      chk("stop_done", 32'(done0), 32'd1);
      chk("stop_cnt", 32'(cnt0), 32'd2);
      start = 1'b1; cyc(); start = 1'b0;
      chk("restart_sysrst", 32'(sr0), 32'd1);
      chk("restart_cnt", 32'(cnt0), 32'd0);

      // rst mid-GAP after two pulses, start held during rst
      repeat (29) cyc();
      rst = 1'b1; start = 1'b1; cyc();
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_cnt", 32'(cnt0), 32'd0);
      cyc();
      rst = 1'b0; start = 1'b0; cyc();
      chk("rst_start_ignored", 32'(busy0), 32'd0);

      // Continuous mode on u2: 100 pulses, then stop
      start = 1'b1; cyc(); start = 1'b0;
      repeat (303) cyc();
      chk("cont_cnt100", 32'(cnt2), 32'd100);
      chk("cont_busy", 32'(busy2), 32'd1);
      chk("cont_notdone", 32'(done2), 32'd0);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("cont_stop_done", 32'(done2), 32'd1);

      // Randomized traffic checked by the model every cycle
      repeat (4000) begin
         rst   = ($urandom_range(249, 0) == 0);
         start = ($urandom_range(11, 0) == 0);
         stop  = ($urandom_range(79, 0) == 0);
         cyc();
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
